// File: rtl/mac_pkg.sv
// Shared definitions for the data-memory access controller: default bus widths and FSM state encodings.
package mac_pkg;

    localparam int MAC_AW  = 8;
    localparam int MAC_DW  = 8;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_RESP  = 3'd3,
        ST_VREAD = 3'd4
    } mac_state_e;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response channel between the execute stage (master) and the memory access controller (slave).
interface mem_access_ctrl_if
    import mac_pkg::*;
#(
    parameter int AW = MAC_AW,
    parameter int DW = MAC_DW
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid;
    logic [DW-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator side of the nRISC data-memory port: one load/store at a time, 2-cycle latency.
// Optional build macro MAC_WRITE_VERIFY_EN adds a read-back check after every store.
module mem_access_ctrl
    import mac_pkg::*;
#(
    parameter int AW = MAC_AW,
    parameter int DW = MAC_DW
)
(
    input  logic            clk,
    input  logic            reset,
    mem_access_ctrl_if.slave req,
    output logic            busy,
    output logic            mem_we,
    output logic            mem_re,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
`ifdef MAC_WRITE_VERIFY_EN
    ,
    output logic            verify_err
`endif
);

    mac_state_e    state_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          accept;

    assign req.req_ready  = ~reset & ((state_q == ST_IDLE) | (state_q == ST_RESP));
    assign accept         = req.req_valid & req.req_ready;
    assign req.resp_valid = (state_q == ST_RESP);
    assign req.resp_rdata = rdata_q;
    assign busy           = (state_q != ST_IDLE);

    // Strobes are gated with reset so a store caught by reset never reaches the array.
    assign mem_we    = ~reset & (state_q == ST_WRITE);
`ifdef MAC_WRITE_VERIFY_EN
    assign mem_re    = ~reset & ((state_q == ST_READ) | (state_q == ST_VREAD));
`else
    assign mem_re    = ~reset & (state_q == ST_READ);
`endif
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

`ifdef MAC_WRITE_VERIFY_EN
    logic verr_q;
    assign verify_err = verr_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MAC_WRITE_VERIFY_EN
            verr_q  <= 1'b0;
`endif
        end else begin
`ifdef MAC_WRITE_VERIFY_EN
            verr_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        addr_q  <= req.req_addr;
                        wdata_q <= req.req_wdata;
                        state_q <= req.req_write ? ST_WRITE : ST_READ;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
`ifdef MAC_WRITE_VERIFY_EN
                    state_q <= ST_VREAD;
`else
                    state_q <= ST_RESP;
`endif
                end
                ST_READ: begin
                    rdata_q <= mem_rdata;
                    state_q <= ST_RESP;
                end
`ifdef MAC_WRITE_VERIFY_EN
                ST_VREAD: begin
                    verr_q  <= (mem_rdata != wdata_q);
                    state_q <= ST_RESP;
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a transaction-level reference model and a 256x8 memory model.
// Build with MAC_WRITE_VERIFY_EN to cover the store read-back path (memory has bit 0 stuck at 0 at 0x30).
module tb_mem_access_ctrl;
    import mac_pkg::*;

`ifdef MAC_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int STORE_LAT = VERIFY ? 3 : 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       busy, mem_we, mem_re;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'h00;
    logic       verify_err;

    mem_access_ctrl_if #(.AW(8), .DW(8)) bus ();

    mem_access_ctrl #(.AW(8), .DW(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (bus),
        .busy      (busy),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef MAC_WRITE_VERIFY_EN
        ,
        .verify_err(verify_err)
`endif
    );

`ifndef MAC_WRITE_VERIFY_EN
    assign verify_err = 1'b0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    // Memory content as seen on a read; the verify build models a cell with bit 0 stuck low.
    function automatic logic [7:0] readback(input logic [7:0] a, input logic [7:0] d);
        if (VERIFY && a == 8'h30) return d & 8'hFE;
        return d;
    endfunction

    logic [7:0] mem [256];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    always @(negedge clk) if (mem_re) mem_rdata <= readback(mem_addr, mem[mem_addr]);

    // Reference model: one outstanding request, tracked by its age in cycles since acceptance.
    logic [7:0] model_mem [256];
    bit         checking = 0;
    bit         pend = 0, p_write = 0;
    int         age = 0, lat;
    logic [7:0] p_addr = 0, p_wdata = 0, m_rdata = 0;
    bit         in_resp, e_ready, e_we, e_re, e_verr;

    always @(negedge clk) if (checking) begin
        lat     = (p_write && VERIFY) ? 3 : 2;
        in_resp = pend && age == lat;
        e_ready = !reset && (!pend || in_resp);
        e_we    = !reset && pend && p_write && age == 1;
        e_re    = !reset && pend && ((!p_write && age == 1) || (VERIFY && p_write && age == 2));
        e_verr  = VERIFY && in_resp && p_write && (readback(p_addr, model_mem[p_addr]) != p_wdata);
        chk("req_ready", bus.req_ready, e_ready);
        chk("busy", busy, pend);
        chk("resp_valid", bus.resp_valid, in_resp);
        chk("mem_we", mem_we, e_we);
        chk("mem_re", mem_re, e_re);
        chk("resp_rdata", bus.resp_rdata, m_rdata);
        chk("verify_err", verify_err, e_verr);
        if (e_we) begin
            chk("mem_addr_wr", mem_addr, p_addr);
            chk("mem_wdata", mem_wdata, p_wdata);
        end
        if (e_re) chk("mem_addr_rd", mem_addr, p_addr);
        if (reset) begin
            pend    = 0;
            m_rdata = 0;
        end else begin
            if (pend && age == 1 && p_write)  model_mem[p_addr] = p_wdata;
            if (pend && age == 1 && !p_write) m_rdata = readback(p_addr, model_mem[p_addr]);
            if (in_resp) pend = 0;
            else if (pend) age++;
            if (bus.req_valid && e_ready) begin
                pend    = 1;
                age     = 1;
                p_write = bus.req_write;
                p_addr  = bus.req_addr;
                p_wdata = bus.req_wdata;
            end
        end
    end

    task automatic do_req(input bit w, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
            if (n > 20) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
    endtask

    task automatic wait_resp(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.resp_valid) break;
            if (n > 10) begin
                chk("resp_timeout", 32'd1, 32'd0);
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int  n;
    bit  seen;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]       = 8'h00;
            model_mem[i] = 8'h00;
        end
        reset         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h10;
        bus.req_wdata = 8'h77;

        // Reset held with a request pending: nothing may move.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checking = 1;
            @(negedge clk);
            chk("rst_ctrl", {bus.req_ready, bus.resp_valid, busy, mem_we, mem_re, verify_err}, 0);
            chk("rst_addr_wdata", {mem_addr, mem_wdata}, 0);
            chk("rst_rdata", bus.resp_rdata, 0);
        end
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        chk("rst_no_store", mem[8'h10], 8'h00);

        // Store then load of the same byte.
        do_req(1'b1, 8'h10, 8'h5A);
        wait_resp(n);
        chk("store_latency", n, STORE_LAT);
        do_req(1'b0, 8'h10, 8'h00);
        wait_resp(n);
        chk("load_latency", n, 2);
        chk("load_5A", bus.resp_rdata, 8'h5A);

        // Back-to-back store/load at the top address, the load accepted during RESP.
        do_req(1'b1, 8'hFF, 8'h01);
        do_req(1'b0, 8'hFF, 8'h00);
        wait_resp(n);
        chk("b2b_latency", n, 2);
        chk("b2b_load_01", bus.resp_rdata, 8'h01);

        // Reset landing on the WRITE cycle of a store.
        do_req(1'b1, 8'h20, 8'h33);
        wait_resp(n);
        do_req(1'b1, 8'h20, 8'hAA);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_write_we", mem_we, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen  = 0;
        repeat (3) begin
            @(negedge clk);
            seen |= bus.resp_valid;
        end
        chk("abort_no_resp", seen, 1'b0);
        chk("abort_mem", mem[8'h20], 8'h33);
        do_req(1'b0, 8'h20, 8'h00);
        wait_resp(n);
        chk("abort_load", bus.resp_rdata, 8'h33);

        // A store request shown only while busy, then withdrawn.
        do_req(1'b0, 8'h10, 8'h00);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 8'h40;
        bus.req_wdata = 8'hEE;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(n);
        chk("busy_load_5A", bus.resp_rdata, 8'h5A);
        repeat (4) @(negedge clk);
        chk("ignored_mem", mem[8'h40], 8'h00);
        chk("ignored_idle", busy, 1'b0);

`ifdef MAC_WRITE_VERIFY_EN
        // Read-back check against the stuck-at cell.
        do_req(1'b1, 8'h30, 8'h81);
        wait_resp(n);
        chk("verify_latency", n, 3);
        chk("verify_err_81", verify_err, 1'b1);
        do_req(1'b1, 8'h30, 8'h80);
        wait_resp(n);
        chk("verify_latency2", n, 3);
        chk("verify_err_80", verify_err, 1'b0);
        do_req(1'b0, 8'h30, 8'h00);
        wait_resp(n);
        chk("verify_load", bus.resp_rdata, 8'h80);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
